drum_step_ctrl: RTL and testbench

Time-step sequencer for the FDN drum node array. It owns the array's shared `node_reset` and `node_en` and drives the strike amplitude onto `u_init`. On each audio sample request it advances the array by `STEPS_PER_SAMPLE` time steps, then captures the probe node's displacement as one output sample. It sits between the audio codec interface and the compute-node grid.

---
 rtl/drum_pkg.sv | 16 +
 rtl/drum_step_ctrl.sv | 149 ++++++++++++++
 tb/tb_drum_step_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_pkg.sv
// Shared types and constants for the FDN drum node array and its step sequencer.
package drum_pkg;

  localparam int unsigned FIX_W            = 18;
  localparam logic [FIX_W-1:0] ONE         = 18'h1_0000;
  localparam int unsigned NODE_STEP_CYCLES = 4;

  typedef enum logic [2:0] {
    StClr,
    StLoad,
    StWait,
    StRun,
    StCap
  } state_e;

endpackage

// File: rtl/drum_step_ctrl.sv
// Time-step sequencer: advances the node array STEPS_PER_SAMPLE steps per audio sample
// request, captures the probe node's displacement, and handles strike re-initialisation.
module drum_step_ctrl
  import drum_pkg::*;
#(
  parameter int unsigned STEPS_PER_SAMPLE = 1,
  parameter int unsigned TIMEOUT          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strike,
  input  logic [FIX_W-1:0] strike_amp,
  input  logic             sample_req,
  input  logic             node_valid,
  input  logic [FIX_W-1:0] node_u,
  output logic             node_en,
  output logic             node_reset,
  output logic [FIX_W-1:0] u_init,
  output logic [FIX_W-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int unsigned STEP_W = $clog2(STEPS_PER_SAMPLE + 1);
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  localparam logic [STEP_W-1:0] StepsInit = STEP_W'(STEPS_PER_SAMPLE);
  localparam logic [STEP_W-1:0] StepLast  = STEP_W'(1);
  // Watchdog fires in the TIMEOUT-th RUN cycle without a probe valid.
  localparam logic [WD_W-1:0]   WdLast    = WD_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [FIX_W-1:0]   amp_q, amp_d;
  logic               strike_pend_q, strike_pend_d;
  logic               req_pend_q, req_pend_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FIX_W-1:0]   sample_out_q, sample_out_d;
  logic               sample_valid_q, sample_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  always_comb begin
    state_d        = state_q;
    amp_d          = amp_q;
    strike_pend_d  = strike_pend_q;
    req_pend_d     = req_pend_q;
    step_d         = step_q;
    wd_d           = wd_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = overrun_q;
    timeout_d      = timeout_q;

    if (strike) begin
      strike_pend_d = 1'b1;
      amp_d         = strike_amp;
    end

    // One-deep request queue; a request arriving on a full queue is dropped.
    if (sample_req) begin
      if (req_pend_q) begin
        overrun_d = 1'b1;
      end else begin
        req_pend_d = 1'b1;
      end
    end

    unique case (state_q)
      StClr:  state_d = StLoad;
      StLoad: state_d = StWait;
      StWait: begin
        if (strike_pend_q || strike) begin
          state_d       = StClr;
          strike_pend_d = 1'b0;
        end else if (req_pend_q || sample_req) begin
          state_d    = StRun;
          req_pend_d = 1'b0;
          step_d     = StepsInit;
          wd_d       = '0;
        end
      end
      StRun: begin
        if (node_valid) begin
          wd_d   = '0;
          step_d = step_q - STEP_W'(1);
          if (step_q == StepLast) begin
            state_d = StCap;
          end
        end else if (wd_q == WdLast) begin
          // Stalled array: force a re-init from rest and drop the sample.
          timeout_d     = 1'b1;
          strike_pend_d = 1'b1;
          amp_d         = '0;
          state_d       = StClr;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      StCap: begin
        sample_out_d   = node_u;
        sample_valid_d = 1'b1;
        state_d        = StWait;
      end
      default: state_d = StClr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StClr;
      amp_q          <= '0;
      strike_pend_q  <= 1'b0;
      req_pend_q     <= 1'b0;
      step_q         <= '0;
      wd_q           <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      amp_q          <= amp_d;
      strike_pend_q  <= strike_pend_d;
      req_pend_q     <= req_pend_d;
      step_q         <= step_d;
      wd_q           <= wd_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    node_reset = (state_q == StClr);
    node_en    = (state_q == StClr) || (state_q == StLoad) || (state_q == StRun);
    u_init     = ((state_q == StClr) || (state_q == StLoad)) ? amp_q : '0;
    busy       = (state_q != StWait);
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_drum_step_ctrl.sv
// Directed self-checking bench for drum_step_ctrl with a behavioural probe-node model.
module tb_drum_step_ctrl;
  import drum_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, strike, req1, req3, gate1;
  logic [FIX_W-1:0] strike_amp, probe_u;

  logic             en1, nrst1, sv1, busy1, ovr1, to1, nv1;
  logic [FIX_W-1:0] uinit1, sout1;
  logic             en3, nrst3, sv3, busy3, ovr3, to3, nv3;
  logic [FIX_W-1:0] uinit3, sout3;

  int checks = 0;
  int failures = 0;

  drum_step_ctrl #(.STEPS_PER_SAMPLE(1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .strike(strike), .strike_amp(strike_amp),
    .sample_req(req1), .node_valid(nv1), .node_u(probe_u),
    .node_en(en1), .node_reset(nrst1), .u_init(uinit1), .sample_out(sout1),
    .sample_valid(sv1), .busy(busy1), .overrun(ovr1), .timeout_err(to1)
  );

  drum_step_ctrl #(.STEPS_PER_SAMPLE(3), .TIMEOUT(8)) dut3 (
    .clk(clk), .reset(reset), .strike(1'b0), .strike_amp(18'h0),
    .sample_req(req3), .node_valid(nv3), .node_u(probe_u),
    .node_en(en3), .node_reset(nrst3), .u_init(uinit3), .sample_out(sout3),
    .sample_valid(sv3), .busy(busy3), .overrun(ovr3), .timeout_err(to3)
  );

  // Probe node: first enabled cycle after node_reset is sInit, then 4-cycle steps.
  logic [1:0] ph1, ph3;
  logic       init1, init3;
  always_ff @(posedge clk) begin
    if (nrst1) begin
      ph1 <= 2'd0; init1 <= 1'b0;
    end else if (en1) begin
      if (!init1) init1 <= 1'b1;
      else        ph1 <= ph1 + 2'd1;
    end
    if (nrst3) begin
      ph3 <= 2'd0; init3 <= 1'b0;
    end else if (en3) begin
      if (!init3) init3 <= 1'b1;
      else        ph3 <= ph3 + 2'd1;
    end
  end
  assign nv1 = gate1 & en1 & ~nrst1 & init1 & (ph1 == 2'd3);
  assign nv3 = en3 & ~nrst3 & init3 & (ph3 == 2'd3);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if ({nrst1, en1, sv1, ovr1, to1} !== 5'b11000 || uinit1 !== '0) begin
        failures++;
        $display("FAIL reset_hold: nrst,en,sv,ovr,to=%b u_init=%h, want 11000 u_init=0",
                 {nrst1, en1, sv1, ovr1, to1}, uinit1);
      end
    end
    reset = 1'b0;
    checks++;
    if ({nrst1, en1, busy1} !== 3'b111 || uinit1 !== '0) begin
      failures++;
      $display("FAIL reset_clr_after: nrst,en,busy=%b u_init=%h, want 111 0",
               {nrst1, en1, busy1}, uinit1);
    end
    tick();
    checks++;
    if ({nrst1, en1, busy1, sv1} !== 4'b0110 || uinit1 !== '0) begin
      failures++;
      $display("FAIL reset_load: nrst,en,busy,sv=%b u_init=%h, want 0110 0",
               {nrst1, en1, busy1, sv1}, uinit1);
    end
    tick();
    checks++;
    if ({nrst1, en1, busy1, sv1, ovr1, to1} !== 6'b0 || {nrst3, en3, busy3} !== 3'b0) begin
      failures++;
      $display("FAIL reset_wait: dut1 nrst,en,busy,sv,ovr,to=%b dut3 nrst,en,busy=%b, want 0",
               {nrst1, en1, busy1, sv1, ovr1, to1}, {nrst3, en3, busy3});
    end
  endtask

  task automatic test_single();
    logic ee, es, eb;
    probe_u = ONE >> 2;
    for (int c = 0; c <= 8; c++) begin
      req1 = (c == 0);
      ee = (c >= 1 && c <= 4);
      es = (c == 6);
      eb = (c >= 1 && c <= 5);
      checks++;
      if ({en1, sv1, busy1, nrst1} !== {ee, es, eb, 1'b0}) begin
        failures++;
        $display("FAIL single_c%0d: en,sv,busy,nrst=%b, want %b", c,
                 {en1, sv1, busy1, nrst1}, {ee, es, eb, 1'b0});
      end
      if (c == 6) begin
        checks++;
        if (sout1 !== 18'h0_4000) begin
          failures++;
          $display("FAIL single_sample: sample_out=%h, want 04000", sout1);
        end
      end
      tick();
    end
    req1 = 1'b0;
  endtask

  task automatic test_steps();
    int nvalid = 0;
    logic ee, es;
    for (int c = 0; c <= 16; c++) begin
      req3 = (c == 0);
      ee = (c >= 1 && c <= 3 * NODE_STEP_CYCLES);
      es = (c == 14);
      if (nv3 === 1'b1) nvalid++;
      checks++;
      if ({en3, sv3, nrst3} !== {ee, es, 1'b0} || uinit3 !== '0) begin
        failures++;
        $display("FAIL steps_c%0d: en,sv,nrst=%b u_init=%h, want %b 0", c,
                 {en3, sv3, nrst3}, uinit3, {ee, es, 1'b0});
      end
      if (c == 14) begin
        checks++;
        if (sout3 !== 18'h0_4000) begin
          failures++;
          $display("FAIL steps_sample: sample_out=%h, want 04000", sout3);
        end
      end
      tick();
    end
    req3 = 1'b0;
    checks++;
    if (nvalid != 3) begin
      failures++;
      $display("FAIL steps_valids: got %0d, want 3", nvalid);
    end
  endtask

  task automatic test_strike_mid_run();
    logic ee, en, es, eb;
    logic [FIX_W-1:0] eu;
    probe_u    = 18'h3_C000;
    strike_amp = 18'h3_0000;
    for (int c = 0; c <= 10; c++) begin
      req1   = (c == 0);
      strike = (c == 2);
      ee = (c >= 1 && c <= 4) || c == 7 || c == 8;
      en = (c == 7);
      es = (c == 6);
      eb = (c >= 1 && c <= 5) || c == 7 || c == 8;
      eu = (c == 7 || c == 8) ? 18'h3_0000 : 18'h0;
      checks++;
      if ({en1, nrst1, sv1, busy1} !== {ee, en, es, eb} || uinit1 !== eu) begin
        failures++;
        $display("FAIL strike_c%0d: en,nrst,sv,busy=%b u_init=%h, want %b %h", c,
                 {en1, nrst1, sv1, busy1}, uinit1, {ee, en, es, eb}, eu);
      end
      if (c == 6) begin
        checks++;
        if (sout1 !== 18'h3_C000) begin
          failures++;
          $display("FAIL strike_sample: sample_out=%h, want 3c000", sout1);
        end
      end
      tick();
    end
    req1   = 1'b0;
    strike = 1'b0;
  endtask

  task automatic test_sim_overrun();
    logic ee, en, es, eo, eb;
    logic [FIX_W-1:0] eu;
    int nsv = 0;
    probe_u    = ONE >> 2;
    strike_amp = 18'h0_8000;
    for (int c = 0; c <= 17; c++) begin
      req1   = (c == 0 || c == 5 || c == 6);
      strike = (c == 0);
      en = (c == 1);
      ee = (c == 1 || c == 2) || (c >= 4 && c <= 7) || (c >= 10 && c <= 13);
      es = (c == 9 || c == 15);
      eo = (c >= 7);
      eb = (c == 1 || c == 2) || (c >= 4 && c <= 8) || (c >= 10 && c <= 14);
      eu = (c == 1 || c == 2) ? 18'h0_8000 : 18'h0;
      if (sv1 === 1'b1) nsv++;
      checks++;
      if ({nrst1, en1, sv1, ovr1, busy1} !== {en, ee, es, eo, eb} || uinit1 !== eu) begin
        failures++;
        $display("FAIL simul_c%0d: nrst,en,sv,ovr,busy=%b u_init=%h, want %b %h", c,
                 {nrst1, en1, sv1, ovr1, busy1}, uinit1, {en, ee, es, eo, eb}, eu);
      end
      tick();
    end
    req1   = 1'b0;
    strike = 1'b0;
    checks++;
    if (nsv != 2) begin
      failures++;
      $display("FAIL simul_samples: got %0d, want 2", nsv);
    end
  endtask

  task automatic test_watchdog();
    logic ee, en, et;
    gate1 = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      req1 = (c == 0);
      ee = (c >= 1);
      en = (c == 9);
      et = (c >= 9);
      checks++;
      if ({en1, nrst1, to1, sv1} !== {ee, en, et, 1'b0} || uinit1 !== '0) begin
        failures++;
        $display("FAIL watchdog_c%0d: en,nrst,to,sv=%b u_init=%h, want %b 0", c,
                 {en1, nrst1, to1, sv1}, uinit1, {ee, en, et, 1'b0});
      end
      tick();
    end
    req1 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (sv1 !== 1'b0 || uinit1 !== '0) begin
        failures++;
        $display("FAIL watchdog_settle_c%0d: sv=%b u_init=%h, want 0 0", c, sv1, uinit1);
      end
      tick();
    end
    gate1 = 1'b1;
  endtask

  task automatic test_recover();
    checks++;
    if ({busy1, to1} !== 2'b01) begin
      failures++;
      $display("FAIL recover_idle: busy,to=%b, want 01", {busy1, to1});
    end
    probe_u = 18'h1_2345;
    for (int c = 0; c <= 7; c++) begin
      req1 = (c == 0);
      checks++;
      if (sv1 !== (c == 6)) begin
        failures++;
        $display("FAIL recover_c%0d: sv=%b, want %b", c, sv1, (c == 6));
      end
      if (c == 6) begin
        checks++;
        if (sout1 !== 18'h1_2345) begin
          failures++;
          $display("FAIL recover_sample: sample_out=%h, want 12345", sout1);
        end
      end
      tick();
    end
    req1 = 1'b0;
    checks++;
    if ({ovr3, to3} !== 2'b00) begin
      failures++;
      $display("FAIL dut3_flags: ovr,to=%b, want 00", {ovr3, to3});
    end
  endtask

  initial begin
    reset      = 1'b1;
    strike     = 1'b0;
    strike_amp = '0;
    req1       = 1'b0;
    req3       = 1'b0;
    gate1      = 1'b1;
    probe_u    = '0;
    test_reset();
    test_single();
    test_steps();
    test_strike_mid_run();
    test_sim_overrun();
    test_watchdog();
    test_recover();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
